// File: rtl/fifo_pkg.sv
// fifo_pkg: default geometry and derived widths shared by the FIFO and its users
//   FIFO_WIDTH  default data word width
//   FIFO_DEPTH  default number of entries (power of two, >= 4)
//   ADDR_W      pointer width for the default depth
//   CNT_W       occupancy counter width (one extra bit so "full" is representable)
package fifo_pkg;
    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = ADDR_W + 1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered ack/error pulses and count-derived status
//   clk, rst     clock and synchronous active-high reset
//   data_in      write data, stored when wr_en is set and the FIFO is not full
//   wr_en/rd_en  write/read requests
//   data_out     registered read data, updated the cycle after an accepted read
//   wr_ack       write accepted last cycle
//   overflow     write rejected (full) last cycle
//   underflow    read rejected (empty) last cycle
//   full/empty/almostfull/almostempty  combinational occupancy flags
module sync_fifo #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_ok, rd_ok;

    assign full        = count_q == CW'(FIFO_DEPTH);
    assign empty       = count_q == '0;
    assign almostfull  = count_q == CW'(FIFO_DEPTH - 1);
    assign almostempty = count_q == CW'(1);

    // Gating on pre-cycle full/empty gives read-only when full and write-only when empty.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok && !rst)
            mem[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_ok;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                data_out_q <= mem[rd_ptr_q];
            end
            count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench; stimulus pushes expected responses, monitor compares
module tb_sync_fifo;
    typedef struct packed {
        logic [15:0] d;
        logic        ack, ovf, udf, fu, em, af, ae;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] m_dout = '0;
    int          total = 0, bad = 0, cyc = 0;

    sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Drive one cycle and enqueue what the DUT must show after the next rising edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [15:0] din);
        exp_t e;
        logic was_full, was_empty;
        @(negedge clk);
        rst = r; wr_en = w; rd_en = rd; data_in = din;
        was_full  = mq.size() == 8;
        was_empty = mq.size() == 0;
        if (r) begin
            mq.delete();
            m_dout = '0;
            e.ack = 0; e.ovf = 0; e.udf = 0;
        end else begin
            e.ack = w && !was_full;
            e.ovf = w && was_full;
            e.udf = rd && was_empty;
            if (rd && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full) mq.push_back(din);
        end
        e.d  = m_dout;
        e.fu = mq.size() == 8;
        e.em = mq.size() == 0;
        e.af = mq.size() == 7;
        e.ae = mq.size() == 1;
        exp_q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("data_out", data_out, e.d);
            chk("wr_ack", 16'(wr_ack), 16'(e.ack));
            chk("overflow", 16'(overflow), 16'(e.ovf));
            chk("underflow", 16'(underflow), 16'(e.udf));
            chk("full", 16'(full), 16'(e.fu));
            chk("empty", 16'(empty), 16'(e.em));
            chk("almostfull", 16'(almostfull), 16'(e.af));
            chk("almostempty", 16'(almostempty), 16'(e.ae));
        end
    end

    initial begin
        repeat (3) step(1, 1, 1, 16'hFFFF);
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 16'(i));
        for (int i = 0; i < 9; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0010 + 16'(i));
        step(0, 1, 1, 16'h00AA);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h0);
        step(0, 1, 1, 16'h00BB);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0100 + 16'(i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, 16'h0104 + 16'(i));
        step(0, 1, 0, 16'h0200);
        step(1, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
